cmi_decode: RTL and testbench



---
 rtl/cmi_decode.sv | 159 +++++++++++++++
 tb/tb_cmi_decode.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cmi_decode.sv
// cmi_decode: 8x oversampling CMI receiver that aligns on falling line edges and recovers NRZ data.
// Optional mark-alternation check is enabled by defining CMI_DEC_AMI_CHECK_EN.
module cmi_decode #(
    parameter int ERR_W = 8
) (
    input  logic             CP,
    input  logic             RST,
    input  logic             CMI,
    output logic             D,
    output logic             DV,
    output logic             LOCK,
    output logic             CV,
    output logic [ERR_W-1:0] ERRCNT
);

    localparam logic [0:0] ST_HUNT   = 1'b0;
    localparam logic [0:0] ST_LOCKED = 1'b1;

    logic             s1_q, s1_d;
    logic             s2_q, s2_d;
    logic             s3_q, s3_d;
    logic [2:0]       ph_q, ph_d;
    logic             h1_q, h1_d;
    logic             h2_q, h2_d;
    logic [0:0]       state_q, state_d;
    logic [1:0]       cvrun_q, cvrun_d;
    logic             d_q, d_d;
    logic             dv_q, dv_d;
    logic             cv_q, cv_d;
    logic [ERR_W-1:0] errcnt_q, errcnt_d;
`ifdef CMI_DEC_AMI_CHECK_EN
    logic             last_pol_q, last_pol_d;
    logic             one_seen_q, one_seen_d;
`endif

    logic fe;
    logic viol;
    logic edge_window;

    assign fe          = s3_q & ~s2_q;
    assign edge_window = (ph_q == 3'd7) || (ph_q == 3'd0) || (ph_q == 3'd1);

    always_comb begin
        s1_d     = CMI;
        s2_d     = s1_q;
        s3_d     = s2_q;
        ph_d     = ph_q + 3'd1;
        h1_d     = h1_q;
        h2_d     = h2_q;
        state_d  = state_q;
        cvrun_d  = cvrun_q;
        d_d      = d_q;
        dv_d     = 1'b0;
        cv_d     = 1'b0;
        errcnt_d = errcnt_q;
        viol     = 1'b0;
`ifdef CMI_DEC_AMI_CHECK_EN
        last_pol_d = last_pol_q;
        one_seen_d = one_seen_q;
`endif

        // Mid-half samples leave two cycles of margin for +-1 cycle line jitter.
        if (ph_q == 3'd2) h1_d = s2_q;
        if (ph_q == 3'd6) h2_d = s2_q;

        case (state_q)
            ST_HUNT: begin
                if (fe) begin
                    ph_d    = 3'd1;
                    cvrun_d = 2'd0;
                    state_d = ST_LOCKED;
`ifdef CMI_DEC_AMI_CHECK_EN
                    one_seen_d = 1'b0;
`endif
                end
            end
            ST_LOCKED: begin
                if (fe && edge_window) ph_d = 3'd1;
                // DV is a single-cycle strobe with no back-pressure; D and CV are only meaningful while DV=1.
                if (ph_q == 3'd7) begin
                    dv_d = 1'b1;
                    case ({h1_q, h2_q})
                        2'b01: d_d = 1'b0;
                        2'b10: begin
                            d_d  = 1'b0;
                            viol = 1'b1;
                        end
                        default: begin
                            d_d = 1'b1;
`ifdef CMI_DEC_AMI_CHECK_EN
                            if (one_seen_q && (h1_q == last_pol_q)) viol = 1'b1;
                            last_pol_d = h1_q;
                            one_seen_d = 1'b1;
`endif
                        end
                    endcase
                    cv_d = viol;
                    if (viol) begin
                        if (errcnt_q != {ERR_W{1'b1}}) errcnt_d = errcnt_q + ERR_W'(1);
                        if (cvrun_q == 2'd3) begin
                            cvrun_d = 2'd0;
                            state_d = ST_HUNT;
                        end else begin
                            cvrun_d = cvrun_q + 2'd1;
                        end
                    end else begin
                        cvrun_d = 2'd0;
                    end
                end
            end
            default: state_d = ST_HUNT;
        endcase
    end

    always_ff @(posedge CP) begin
        if (RST) begin
            s1_q     <= 1'b1;
            s2_q     <= 1'b1;
            s3_q     <= 1'b1;
            ph_q     <= 3'd0;
            h1_q     <= 1'b0;
            h2_q     <= 1'b0;
            state_q  <= ST_HUNT;
            cvrun_q  <= 2'd0;
            d_q      <= 1'b0;
            dv_q     <= 1'b0;
            cv_q     <= 1'b0;
            errcnt_q <= '0;
`ifdef CMI_DEC_AMI_CHECK_EN
            last_pol_q <= 1'b0;
            one_seen_q <= 1'b0;
`endif
        end else begin
            s1_q     <= s1_d;
            s2_q     <= s2_d;
            s3_q     <= s3_d;
            ph_q     <= ph_d;
            h1_q     <= h1_d;
            h2_q     <= h2_d;
            state_q  <= state_d;
            cvrun_q  <= cvrun_d;
            d_q      <= d_d;
            dv_q     <= dv_d;
            cv_q     <= cv_d;
            errcnt_q <= errcnt_d;
`ifdef CMI_DEC_AMI_CHECK_EN
            last_pol_q <= last_pol_d;
            one_seen_q <= one_seen_d;
`endif
        end
    end

    assign D      = d_q;
    assign DV     = dv_q;
    assign CV     = cv_q;
    assign LOCK   = (state_q == ST_LOCKED);
    assign ERRCNT = errcnt_q;

endmodule

// File: tb/tb_cmi_decode.sv
// Directed bench for cmi_decode: CMI line driver, DV monitor, and per-scenario tasks with inline checks.
module tb_cmi_decode;

    localparam int ERR_W = 8;

    logic             CP;
    logic             RST;
    logic             CMI;
    logic             D;
    logic             DV;
    logic             LOCK;
    logic             CV;
    logic [ERR_W-1:0] ERRCNT;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    logic enc_last;
    logic [14:0] pat = 15'b000000001010111;

    logic [1:0] exp_q[$];
    logic [1:0] obs_q[$];
    int         t_q[$];

    cmi_decode #(.ERR_W(ERR_W)) dut (
        .CP(CP), .RST(RST), .CMI(CMI), .D(D), .DV(DV),
        .LOCK(LOCK), .CV(CV), .ERRCNT(ERRCNT)
    );

    // clock / reset
    initial CP = 1'b0;
    always #5 CP = ~CP;
    always @(posedge CP) cyc <= cyc + 1;

    // decoded-bit monitor, sampled away from the active edge
    always @(negedge CP) begin
        if (DV === 1'b1) begin
            obs_q.push_back({D, CV});
            t_q.push_back(cyc);
        end
    end

    // driver tasks (all entered and left at posedge + 1)
    task automatic idle(input int n);
        repeat (n) @(posedge CP);
        #1;
    endtask

    task automatic drive_half(input logic lvl, input int n);
        CMI = lvl;
        repeat (n) @(posedge CP);
        #1;
    endtask

    task automatic send_bit(input logic b, input int len);
        if (!b) begin
            drive_half(1'b0, len - 4);
            drive_half(1'b1, 4);
        end else begin
            enc_last = ~enc_last;
            drive_half(enc_last, len - 4);
            drive_half(enc_last, 4);
        end
    endtask

    task automatic send_pair(input logic a, input logic b);
        drive_half(a, 4);
        drive_half(b, 4);
        if (a == b) enc_last = a;
    endtask

    task automatic do_reset();
        RST = 1'b1;
        CMI = 1'b1;
        repeat (2) @(posedge CP);
        #1;
        RST = 1'b0;
        enc_last = 1'b0;
        exp_q.delete();
        obs_q.delete();
        t_q.delete();
        idle(3);
    endtask

    task automatic test_reset();
        RST = 1'b1;
        CMI = 1'b1;
        repeat (3) @(posedge CP);
        #1;
        n_checks++; if (D !== 1'b0) begin n_fail++; $display("FAIL reset_d: got %b expected 0", D); end
        n_checks++; if (DV !== 1'b0) begin n_fail++; $display("FAIL reset_dv: got %b expected 0", DV); end
        n_checks++; if (LOCK !== 1'b0) begin n_fail++; $display("FAIL reset_lock: got %b expected 0", LOCK); end
        n_checks++; if (CV !== 1'b0) begin n_fail++; $display("FAIL reset_cv: got %b expected 0", CV); end
        n_checks++; if (ERRCNT !== 8'd0) begin n_fail++; $display("FAIL reset_errcnt: got %0d expected 0", ERRCNT); end
        RST = 1'b0;
        idle(10);
        n_checks++; if (LOCK !== 1'b0) begin n_fail++; $display("FAIL idle_lock: got %b expected 0", LOCK); end
        n_checks++; if (obs_q.size() != 0) begin n_fail++; $display("FAIL idle_dv: got %0d strobes expected 0", obs_q.size()); end
    endtask

    task automatic test_stream();
        logic b;
        do_reset();
        idle($urandom_range(0, 7));
        for (int rep = 0; rep < 2; rep++) begin
            for (int i = 0; i < 15; i++) begin
                b = pat[14-i];
                send_bit(b, 8);
                exp_q.push_back({b, 1'b0});
                if (rep == 0 && i == 1) begin
                    n_checks++;
                    if (LOCK !== 1'b1) begin n_fail++; $display("FAIL stream_lock2: got %b expected 1", LOCK); end
                end
            end
        end
        idle(6);
        n_checks++;
        if (obs_q.size() != exp_q.size()) begin n_fail++; $display("FAIL stream_count: got %0d expected %0d", obs_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            n_checks++;
            if (obs_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL stream_bit%0d: got D,CV=%b expected %b", i, obs_q[i], exp_q[i]); end
        end
        for (int i = 1; i < t_q.size(); i++) begin
            n_checks++;
            if (t_q[i] - t_q[i-1] != 8) begin n_fail++; $display("FAIL stream_gap%0d: got %0d expected 8", i, t_q[i] - t_q[i-1]); end
        end
        n_checks++; if (ERRCNT !== 8'd0) begin n_fail++; $display("FAIL stream_errcnt: got %0d expected 0", ERRCNT); end
    endtask

    task automatic test_single_cv();
        do_reset();
        for (int i = 0; i < 3; i++) begin send_bit(1'b0, 8); exp_q.push_back(2'b00); end
        send_pair(1'b1, 1'b0);
        exp_q.push_back(2'b01);
        for (int i = 0; i < 3; i++) begin send_bit(1'b0, 8); exp_q.push_back(2'b00); end
        idle(6);
        n_checks++;
        if (obs_q.size() != exp_q.size()) begin n_fail++; $display("FAIL cv1_count: got %0d expected %0d", obs_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            n_checks++;
            if (obs_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL cv1_bit%0d: got D,CV=%b expected %b", i, obs_q[i], exp_q[i]); end
        end
        n_checks++; if (ERRCNT !== 8'd1) begin n_fail++; $display("FAIL cv1_errcnt: got %0d expected 1", ERRCNT); end
        n_checks++; if (LOCK !== 1'b1) begin n_fail++; $display("FAIL cv1_lock: got %b expected 1", LOCK); end
    endtask

    task automatic test_ami();
        logic exp_cv;
`ifdef CMI_DEC_AMI_CHECK_EN
        exp_cv = 1'b1;
`else
        exp_cv = 1'b0;
`endif
        do_reset();
        for (int i = 0; i < 3; i++) begin send_bit(1'b0, 8); exp_q.push_back(2'b00); end
        send_pair(1'b1, 1'b1);
        exp_q.push_back(2'b10);
        send_pair(1'b1, 1'b1);
        exp_q.push_back({1'b1, exp_cv});
        for (int i = 0; i < 2; i++) begin send_bit(1'b0, 8); exp_q.push_back(2'b00); end
        idle(6);
        n_checks++;
        if (obs_q.size() != exp_q.size()) begin n_fail++; $display("FAIL ami_count: got %0d expected %0d", obs_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            n_checks++;
            if (obs_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL ami_bit%0d: got D,CV=%b expected %b", i, obs_q[i], exp_q[i]); end
        end
        n_checks++; if (ERRCNT !== {7'd0, exp_cv}) begin n_fail++; $display("FAIL ami_errcnt: got %0d expected %0d", ERRCNT, exp_cv); end
    endtask

    task automatic test_four_cv();
        do_reset();
        for (int i = 0; i < 2; i++) begin send_bit(1'b0, 8); exp_q.push_back(2'b00); end
        for (int i = 0; i < 3; i++) begin send_pair(1'b1, 1'b0); exp_q.push_back(2'b01); end
        drive_half(1'b1, 4);
        n_checks++; if (LOCK !== 1'b1) begin n_fail++; $display("FAIL cv4_lock_after3: got %b expected 1", LOCK); end
        drive_half(1'b0, 4);
        exp_q.push_back(2'b01);
        drive_half(1'b0, 4);
        n_checks++; if (LOCK !== 1'b0) begin n_fail++; $display("FAIL cv4_unlock: got %b expected 0", LOCK); end
        n_checks++; if (ERRCNT !== 8'd4) begin n_fail++; $display("FAIL cv4_errcnt: got %0d expected 4", ERRCNT); end
        for (int i = 0; i < 15; i++) begin
            send_bit(pat[14-i], 8);
            if (i > 0) exp_q.push_back({pat[14-i], 1'b0});
        end
        idle(6);
        n_checks++;
        if (obs_q.size() != exp_q.size()) begin n_fail++; $display("FAIL cv4_count: got %0d expected %0d", obs_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            n_checks++;
            if (obs_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL cv4_bit%0d: got D,CV=%b expected %b", i, obs_q[i], exp_q[i]); end
        end
        n_checks++; if (LOCK !== 1'b1) begin n_fail++; $display("FAIL cv4_relock: got %b expected 1", LOCK); end
        n_checks++; if (ERRCNT !== 8'd4) begin n_fail++; $display("FAIL cv4_errcnt_end: got %0d expected 4", ERRCNT); end
    endtask

    task automatic test_slip();
        int lens[11] = '{8, 8, 8, 9, 8, 8, 8, 7, 8, 8, 8};
        int gaps[11] = '{0, 8, 8, 8, 9, 8, 8, 8, 7, 8, 8};
        do_reset();
        for (int i = 0; i < 11; i++) begin
            send_bit(1'b0, lens[i]);
            exp_q.push_back(2'b00);
        end
        idle(6);
        n_checks++;
        if (obs_q.size() != exp_q.size()) begin n_fail++; $display("FAIL slip_count: got %0d expected %0d", obs_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            n_checks++;
            if (obs_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL slip_bit%0d: got D,CV=%b expected %b", i, obs_q[i], exp_q[i]); end
        end
        for (int i = 1; i < 11 && i < t_q.size(); i++) begin
            n_checks++;
            if (t_q[i] - t_q[i-1] != gaps[i]) begin n_fail++; $display("FAIL slip_gap%0d: got %0d expected %0d", i, t_q[i] - t_q[i-1], gaps[i]); end
        end
        n_checks++; if (LOCK !== 1'b1) begin n_fail++; $display("FAIL slip_lock: got %b expected 1", LOCK); end
        n_checks++; if (ERRCNT !== 8'd0) begin n_fail++; $display("FAIL slip_errcnt: got %0d expected 0", ERRCNT); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        send_bit(1'b0, 8);
        send_bit(1'b0, 8);
        send_pair(1'b1, 1'b0);
        send_bit(1'b1, 8);
        drive_half(1'b0, 4);
        n_checks++; if (ERRCNT !== 8'd1) begin n_fail++; $display("FAIL rstmid_pre_errcnt: got %0d expected 1", ERRCNT); end
        n_checks++; if (D !== 1'b1) begin n_fail++; $display("FAIL rstmid_pre_d: got %b expected 1", D); end
        n_checks++; if (LOCK !== 1'b1) begin n_fail++; $display("FAIL rstmid_pre_lock: got %b expected 1", LOCK); end
        CMI = 1'b1;
        exp_q.delete();
        obs_q.delete();
        t_q.delete();
        RST = 1'b1;
        @(posedge CP);
        #1;
        RST = 1'b0;
        n_checks++; if (D !== 1'b0) begin n_fail++; $display("FAIL rstmid_d: got %b expected 0", D); end
        n_checks++; if (DV !== 1'b0) begin n_fail++; $display("FAIL rstmid_dv: got %b expected 0", DV); end
        n_checks++; if (LOCK !== 1'b0) begin n_fail++; $display("FAIL rstmid_lock: got %b expected 0", LOCK); end
        n_checks++; if (CV !== 1'b0) begin n_fail++; $display("FAIL rstmid_cv: got %b expected 0", CV); end
        n_checks++; if (ERRCNT !== 8'd0) begin n_fail++; $display("FAIL rstmid_errcnt: got %0d expected 0", ERRCNT); end
        idle(3);
        n_checks++; if (LOCK !== 1'b0) begin n_fail++; $display("FAIL rstmid_nolock: got %b expected 0", LOCK); end
        for (int i = 0; i < 6; i++) begin send_bit(1'b0, 8); exp_q.push_back(2'b00); end
        idle(6);
        n_checks++;
        if (obs_q.size() != exp_q.size()) begin n_fail++; $display("FAIL rstmid_count: got %0d expected %0d", obs_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            n_checks++;
            if (obs_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL rstmid_bit%0d: got D,CV=%b expected %b", i, obs_q[i], exp_q[i]); end
        end
        n_checks++; if (LOCK !== 1'b1) begin n_fail++; $display("FAIL rstmid_relock: got %b expected 1", LOCK); end
    endtask

    task automatic test_saturate();
        int n_cv;
        do_reset();
        send_bit(1'b0, 8);
        for (int i = 0; i < 260; i++) begin
            send_pair(1'b1, 1'b0);
            send_bit(1'b0, 8);
        end
        idle(6);
        n_cv = 0;
        foreach (obs_q[i]) if (obs_q[i][0] === 1'b1) n_cv++;
        n_checks++; if (n_cv != 260) begin n_fail++; $display("FAIL sat_cv_strobes: got %0d expected 260", n_cv); end
        n_checks++; if (ERRCNT !== 8'hFF) begin n_fail++; $display("FAIL sat_errcnt: got %0d expected 255", ERRCNT); end
        n_checks++; if (LOCK !== 1'b1) begin n_fail++; $display("FAIL sat_lock: got %b expected 1", LOCK); end
    endtask

    initial begin
        RST = 1'b1;
        CMI = 1'b1;
        enc_last = 1'b0;
        test_reset();
        test_stream();
        test_single_cv();
        test_ami();
        test_four_cv();
        test_slip();
        test_reset_mid();
        test_saturate();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
